eth_udp_rx: RTL and testbench
=============================

ETH_UDP_RX -- requirements
Module: eth_udp_rx

Interface
REQ-001 SHALL have parameter LOCAL_MAC, default 48'h00_0a_35_01_fe_ca, the station MAC accepted besides broadcast.
REQ-002 SHALL have parameter LOCAL_IP, default 32'hC0A8_0003 (192.168.0.3), the accepted IPv4 destination.
REQ-003 SHALL have parameter LOCAL_PORT, default 16'd6102, the accepted UDP destination port.
REQ-004 SHALL have port gmii_rx_clk, input, 1 bit: the only clock, 125 MHz from the PHY.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port gmii_rx_dv, input, 1 bit: receive data valid.
REQ-007 SHALL have port gmii_rx_er, input, 1 bit: receive error.
REQ-008 SHALL have port gmii_rxd, input, 8 bits: receive byte.
REQ-009 SHALL have port rx_data, output, 8 bits: UDP payload byte.
REQ-010 SHALL have port rx_valid, output, 1 bit: rx_data is valid this cycle.
REQ-011 SHALL have port rx_last, output, 1 bit: marks the final payload byte.
REQ-012 SHALL have port rx_len, output, 16 bits: payload length, equal to UDP length minus 8, valid from the first rx_valid.
REQ-013 SHALL have port rx_src_ip, output, 32 bits, and port rx_src_port, output, 16 bits: sender IP address and sender UDP port, held until the next accepted frame.
REQ-014 SHALL have port rx_done, output, 1 bit: one-cycle pulse at the end of an accepted frame.
REQ-015 SHALL have port rx_crc_ok, output, 1 bit: FCS result, qualified by rx_done.
REQ-016 SHALL have port rx_drop, output, 1 bit: one-cycle pulse when a frame is discarded.

Function
REQ-017 SHALL use FSM states IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, FCS_WAIT, DROP.
REQ-018 SHALL behave as follows in IDLE: gmii_rx_dv high with byte 8'h55 moves to PREAMBLE.
REQ-019 SHALL behave as follows in PREAMBLE: 8'h55 stays; 8'hD5 after at least 1 byte of 8'h55 moves to ETH_HDR; any other byte moves to DROP.
REQ-020 SHALL behave as follows in ETH_HDR (14 bytes): destination MAC must equal LOCAL_MAC or all-ones; ethertype must be 16'h0800.
REQ-021 SHALL behave as follows in IP_HDR (20 bytes): byte0 must be 8'h45; protocol must be 8'h11; destination IP must equal LOCAL_IP; source IP is captured.
REQ-022 SHALL not check the IP header checksum.
REQ-023 SHALL behave as follows in UDP_HDR (8 bytes): destination port must equal LOCAL_PORT; source port and length are captured.
REQ-024 SHALL treat a UDP length below 9 as a mismatch.
REQ-025 SHALL compare each field against its rule on the cycle its last byte arrives; any mismatch moves to DROP.
REQ-026 SHALL, in PAYLOAD, assert rx_valid with rx_data equal to gmii_rxd registered, so rx_data lags gmii_rxd by 1 cycle; rx_last SHALL coincide with payload byte rx_len.
REQ-027 SHALL, in FCS_WAIT, discard padding and FCS until gmii_rx_dv falls, then pulse rx_done, return to IDLE, and drive rx_crc_ok.
REQ-028 SHALL run the CRC-32 over every byte from the first destination-MAC byte through the last FCS byte; rx_crc_ok=1 iff the final residue equals 32'hC704DD7B.
REQ-029 SHALL, in DROP, wait for gmii_rx_dv low, then pulse rx_drop and return to IDLE.
REQ-030 SHALL emit no rx_done for a dropped frame.
REQ-031 SHALL, when gmii_rx_dv falls before FCS_WAIT, pulse rx_drop and return to IDLE.
REQ-032 SHALL, in that early-dv-fall case, assert rx_last on the last payload byte already emitted, if payload has started.
REQ-033 SHALL, when gmii_rx_er is high in any non-IDLE state, force rx_crc_ok=0 at the end of the frame.
REQ-034 SHALL count bytes with a single 11-bit byte counter that clears on every state change.
REQ-035 SHALL saturate that counter at 2047; a frame longer than 2047 bytes moves to DROP.
REQ-036 SHALL, after a frame ends, treat gmii_rx_dv rising on the very next cycle as a new frame.

Reset
REQ-037 SHALL, while rst is high, put the FSM in IDLE, clear the counter, and preset the CRC to all-ones.
REQ-038 SHALL, while rst is high, drive 0 on rx_data, rx_valid, rx_last, rx_len, rx_src_ip, rx_src_port, rx_done, rx_crc_ok and rx_drop.
REQ-039 SHALL, on reset mid-frame, abandon the frame with no rx_done or rx_drop; after release, the module stays in IDLE until the next preamble.

Structure
REQ-040 SHALL place the state encoding, header byte offsets, constants 16'h0800, 8'h45, 8'h11 and 32'hC704DD7B, and the length constants 14/20/8 in shared package eth_pkg.
REQ-041 SHALL implement the byte-wide CRC in one sub-module, crc32_d8_rx, with initialize on IDLE and enable on dv.

Verification
REQ-042 SHALL cover this frame: broadcast destination, source MAC 00:0a:35:01:fe:ca, 192.168.0.2:5000 -> 192.168.0.3:6102, UDP length 0x001E, payload "Hello, welcom to FPGA!" with a correct FCS. Required response: 22 rx_valid bytes 48..21, rx_len=22, rx_last on 8'h21, rx_src_ip=C0A80002, rx_src_port=5000, then rx_done with rx_crc_ok=1.
REQ-043 SHALL cover the same frame with 1 FCS bit flipped: payload is still delivered, and rx_done comes with rx_crc_ok=0.
REQ-044 SHALL cover the same frame with destination port 6103: no rx_valid, and one rx_drop pulse after dv falls.
REQ-045 SHALL cover destination MAC 02:00:00:00:00:01 and, separately, ethertype 0x0806: each gives rx_drop only.
REQ-046 SHALL cover gmii_rx_er held high for 1 payload cycle: rx_crc_ok=0.
REQ-047 SHALL cover rst asserted for 1 cycle at payload byte 10: no rx_done, and a following good frame is received correctly.
REQ-048 SHALL cover back-to-back frames with a 1-cycle dv gap: two rx_done pulses.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the GMII UDP receiver: FSM encoding, header offsets,
// protocol constants and CRC residue.
package eth_pkg;

   typedef enum logic [2:0] {
      IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, FCS_WAIT, DROP
   } state_t;

   localparam int unsigned CNT_W       = 11;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam int unsigned ETH_HDR_LEN = 14;
   localparam int unsigned IP_HDR_LEN  = 20;
   localparam int unsigned UDP_HDR_LEN = 8;

   // Byte index (within the current header) of the last byte of each field
   localparam cnt_t ETH_DST_LAST  = cnt_t'(5);
   localparam cnt_t ETH_TYPE_LAST = cnt_t'(ETH_HDR_LEN - 1);
   localparam cnt_t IP_VER_OFF    = cnt_t'(0);
   localparam cnt_t IP_PROTO_OFF  = cnt_t'(9);
   localparam cnt_t IP_SRC_LAST   = cnt_t'(15);
   localparam cnt_t IP_DST_LAST   = cnt_t'(IP_HDR_LEN - 1);
   localparam cnt_t UDP_SRC_LAST  = cnt_t'(1);
   localparam cnt_t UDP_DST_LAST  = cnt_t'(3);
   localparam cnt_t UDP_LEN_LAST  = cnt_t'(5);
   localparam cnt_t UDP_HDR_LAST  = cnt_t'(UDP_HDR_LEN - 1);
   localparam cnt_t CNT_MAX       = '1;

   localparam logic [7:0]  PRE_BYTE       = 8'h55;
   localparam logic [7:0]  SFD_BYTE       = 8'hD5;
   localparam logic [7:0]  IP_VER_IHL     = 8'h45;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [15:0] UDP_LEN_MIN    = 16'd9;
   localparam logic [15:0] UDP_HDR_BYTES  = 16'd8;
   localparam logic [31:0] CRC_RESIDUE    = 32'hC704DD7B;
   localparam logic [47:0] MAC_BCAST      = '1;

endpackage

// File: rtl/crc32_d8_rx.sv
// Byte-wide Ethernet CRC-32, bits taken LSB first into an MSB-first register,
// so a clean frame+FCS leaves the standard 32'hC704DD7B residue.
module crc32_d8_rx (
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
         else              r = {r[30:0], 1'b0};
      end
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       crc <= '1;
      else if (init) crc <= '1;
      else if (en)   crc <= crc_step(crc, data);
   end

endmodule

// File: rtl/eth_udp_rx.sv
// GMII receiver that filters Ethernet/IPv4/UDP frames for one station and
// streams the UDP payload with sender info, FCS status and drop pulses.
module eth_udp_rx
   import eth_pkg::*;
#(
   parameter logic [47:0] LOCAL_MAC  = 48'h00_0a_35_01_fe_ca,
   parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0003,
   parameter logic [15:0] LOCAL_PORT = 16'd6102
) (
   input  logic        gmii_rx_clk,
   input  logic        rst,
   input  logic        gmii_rx_dv,
   input  logic        gmii_rx_er,
   input  logic [7:0]  gmii_rxd,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_last,
   output logic [15:0] rx_len,
   output logic [31:0] rx_src_ip,
   output logic [15:0] rx_src_port,
   output logic        rx_done,
   output logic        rx_crc_ok,
   output logic        rx_drop
);

   state_t      state;
   cnt_t        cnt;
   logic [39:0] sh;
   logic [47:0] field;
   logic [31:0] src_ip_q;
   logic [15:0] src_port_q;
   logic [15:0] len_q;
   logic        err;
   logic [31:0] crc;
   logic        crc_init;

   // Field ending on the byte currently on the bus
   assign field    = {sh, gmii_rxd};
   assign crc_init = (state == IDLE) || (state == PREAMBLE);

   crc32_d8_rx u_crc (
      .clk  (gmii_rx_clk),
      .rst  (rst),
      .init (crc_init),
      .en   (gmii_rx_dv),
      .data (gmii_rxd),
      .crc  (crc)
   );

   always_ff @(posedge gmii_rx_clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         sh          <= '0;
         src_ip_q    <= '0;
         src_port_q  <= '0;
         len_q       <= '0;
         err         <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         rx_last     <= 1'b0;
         rx_len      <= '0;
         rx_src_ip   <= '0;
         rx_src_port <= '0;
         rx_done     <= 1'b0;
         rx_crc_ok   <= 1'b0;
         rx_drop     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_last  <= 1'b0;
         rx_done  <= 1'b0;
         rx_drop  <= 1'b0;
         if (gmii_rx_dv) sh <= field[39:0];
         if (state != IDLE && gmii_rx_dv && cnt != CNT_MAX) cnt <= cnt + cnt_t'(1);
         if (state == IDLE)   err <= 1'b0;
         else if (gmii_rx_er) err <= 1'b1;

         if (state != IDLE && state != FCS_WAIT && !gmii_rx_dv) begin
            // Frame ended early (or a dropped frame finished): close out payload if any
            rx_drop <= 1'b1;
            rx_last <= (state == PAYLOAD) && (cnt != '0);
            state   <= IDLE;
            cnt     <= '0;
         end else if (state != IDLE && state != DROP && gmii_rx_dv && cnt == CNT_MAX) begin
            state <= DROP;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (gmii_rx_dv && gmii_rxd == PRE_BYTE) begin
                     state <= PREAMBLE;
                     cnt   <= '0;
                  end
               end
               PREAMBLE: begin
                  if (gmii_rxd == SFD_BYTE) begin
                     state <= ETH_HDR;
                     cnt   <= '0;
                  end else if (gmii_rxd != PRE_BYTE) begin
                     state <= DROP;
                     cnt   <= '0;
                  end
               end
               ETH_HDR: begin
                  if (cnt == ETH_DST_LAST && field != LOCAL_MAC && field != MAC_BCAST) begin
                     state <= DROP;
                     cnt   <= '0;
                  end else if (cnt == ETH_TYPE_LAST) begin
                     state <= (field[15:0] == ETHERTYPE_IPV4) ? IP_HDR : DROP;
                     cnt   <= '0;
                  end
               end
               IP_HDR: begin
                  if ((cnt == IP_VER_OFF && gmii_rxd != IP_VER_IHL) ||
                      (cnt == IP_PROTO_OFF && gmii_rxd != IP_PROTO_UDP)) begin
                     state <= DROP;
                     cnt   <= '0;
                  end else if (cnt == IP_SRC_LAST) begin
                     src_ip_q <= field[31:0];
                  end else if (cnt == IP_DST_LAST) begin
                     state <= (field[31:0] == LOCAL_IP) ? UDP_HDR : DROP;
                     cnt   <= '0;
                  end
               end
               UDP_HDR: begin
                  if (cnt == UDP_SRC_LAST) begin
                     src_port_q <= field[15:0];
                  end else if ((cnt == UDP_DST_LAST && field[15:0] != LOCAL_PORT) ||
                               (cnt == UDP_LEN_LAST && field[15:0] < UDP_LEN_MIN)) begin
                     state <= DROP;
                     cnt   <= '0;
                  end else if (cnt == UDP_LEN_LAST) begin
                     len_q <= field[15:0] - UDP_HDR_BYTES;
                  end else if (cnt == UDP_HDR_LAST) begin
                     rx_len      <= len_q;
                     rx_src_ip   <= src_ip_q;
                     rx_src_port <= src_port_q;
                     state       <= PAYLOAD;
                     cnt         <= '0;
                  end
               end
               PAYLOAD: begin
                  rx_valid <= 1'b1;
                  rx_data  <= gmii_rxd;
                  if (16'(cnt) == rx_len - 16'd1) begin
                     rx_last <= 1'b1;
                     state   <= FCS_WAIT;
                     cnt     <= '0;
                  end
               end
               FCS_WAIT: begin
                  if (!gmii_rx_dv) begin
                     rx_done   <= 1'b1;
                     rx_crc_ok <= (crc == CRC_RESIDUE) && !err && !gmii_rx_er;
                     state     <= IDLE;
                     cnt       <= '0;
                  end
               end
               DROP: ;
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_eth_udp_rx.sv
// Directed bench for eth_udp_rx: builds frames with a reference CRC and checks
// payload delivery, filtering, FCS status, reset abandonment and back-to-back frames.
module tb_eth_udp_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dv  = 1'b0;
   logic        er  = 1'b0;
   logic [7:0]  rxd = 8'h00;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_last, rx_done, rx_crc_ok, rx_drop;
   logic [15:0] rx_len, rx_src_port;
   logic [31:0] rx_src_ip;

   always #4 clk = ~clk;

   eth_udp_rx dut (
      .gmii_rx_clk (clk),
      .rst         (rst),
      .gmii_rx_dv  (dv),
      .gmii_rx_er  (er),
      .gmii_rxd    (rxd),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_last     (rx_last),
      .rx_len      (rx_len),
      .rx_src_ip   (rx_src_ip),
      .rx_src_port (rx_src_port),
      .rx_done     (rx_done),
      .rx_crc_ok   (rx_crc_ok),
      .rx_drop     (rx_drop)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor, sampled on the falling edge
   int         n_valid = 0, n_last = 0, n_done = 0, n_drop = 0;
   logic [7:0] pay [0:4095];
   logic [7:0] last_byte = 8'h00;
   logic [15:0] len_seen = 16'h0;
   logic        crc_seen = 1'b0;

   always @(negedge clk) begin
      if (rx_valid) begin
         pay[n_valid[11:0]] = rx_data;
         len_seen = rx_len;
         if (rx_last) begin
            n_last++;
            last_byte = rx_data;
         end
         n_valid++;
      end
      if (rx_done) begin
         n_done++;
         crc_seen = rx_crc_ok;
      end
      if (rx_drop) n_drop++;
   end

   // Frame image (MAC header through FCS)
   logic [7:0] frm [0:127];
   int         flen;
   string      msg = "Hello, welcom to FPGA!";

   task automatic put(input logic [7:0] b);
      frm[flen] = b;
      flen++;
   endtask

   task automatic build(input logic [47:0] dmac, input logic [15:0] etype,
                        input logic [15:0] dport, input logic flip);
      logic [47:0]  smac = 48'h000a3501feca;
      logic [159:0] iph  = 160'h4500_0032_0000_4000_4011_0000_C0A8_0002_C0A8_0003;
      logic [63:0]  udph;
      logic [31:0]  c;
      int           n;
      udph = {16'h1388, dport, 16'h001E, 16'h0000};
      flen = 0;
      for (int i = 5; i >= 0; i--) put(dmac[i*8 +: 8]);
      for (int i = 5; i >= 0; i--) put(smac[i*8 +: 8]);
      put(etype[15:8]);
      put(etype[7:0]);
      for (int i = 19; i >= 0; i--) put(iph[i*8 +: 8]);
      for (int i = 7; i >= 0; i--) put(udph[i*8 +: 8]);
      for (int i = 0; i < msg.len(); i++) put(msg[i]);
      // Reflected CRC-32, FCS sent complemented, least significant byte first
      c = 32'hFFFF_FFFF;
      n = flen;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'h0, frm[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      c = ~c;
      if (flip) c[0] = ~c[0];
      for (int i = 0; i < 4; i++) put(c[i*8 +: 8]);
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic e, input logic r);
      @(posedge clk);
      #1;
      dv  = v;
      rxd = d;
      er  = e;
      rst = r;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   // er_at / rst_at are frame byte indices, -1 for none; a reset cuts dv before the FCS
   task automatic send(input int er_at, input int rst_at);
      int stop;
      stop = (rst_at >= 0) ? 64 : flen;
      repeat (7) drive(1'b1, 8'h55, 1'b0, 1'b0);
      drive(1'b1, 8'hD5, 1'b0, 1'b0);
      for (int i = 0; i < stop; i++) drive(1'b1, frm[i], i == er_at, i == rst_at);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   int v0, l0, d0, p0;

   task automatic snap();
      v0 = n_valid;
      l0 = n_last;
      d0 = n_done;
      p0 = n_drop;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 48'(rx_valid), 48'h0);
      check("rst_done", 48'(rx_done), 48'h0);
      check("rst_drop", 48'(rx_drop), 48'h0);
      check("rst_crc_ok", 48'(rx_crc_ok), 48'h0);
      check("rst_len", 48'(rx_len), 48'h0);
      check("rst_src_ip", 48'(rx_src_ip), 48'h0);
      check("rst_src_port", 48'(rx_src_port), 48'h0);
      check("rst_data", 48'(rx_data), 48'h0);
      idle(4);

      // Good broadcast frame
      build(48'hFFFF_FFFF_FFFF, 16'h0800, 16'd6102, 1'b0);
      snap();
      send(-1, -1);
      idle(8);
      check("good_nvalid", 48'(n_valid - v0), 48'd22);
      for (int i = 0; i < 22; i++) check("good_byte", 48'(pay[12'(v0 + i)]), 48'(msg[i]));
      check("good_first", 48'(pay[12'(v0)]), 48'h48);
      check("good_nlast", 48'(n_last - l0), 48'd1);
      check("good_last_byte", 48'(last_byte), 48'h21);
      check("good_len", 48'(len_seen), 48'd22);
      check("good_src_ip", 48'(rx_src_ip), 48'hC0A8_0002);
      check("good_src_port", 48'(rx_src_port), 48'd5000);
      check("good_ndone", 48'(n_done - d0), 48'd1);
      check("good_crc_ok", 48'(crc_seen), 48'd1);
      check("good_ndrop", 48'(n_drop - p0), 48'd0);

      // FCS bit flipped
      build(48'hFFFF_FFFF_FFFF, 16'h0800, 16'd6102, 1'b1);
      snap();
      send(-1, -1);
      idle(8);
      check("badfcs_nvalid", 48'(n_valid - v0), 48'd22);
      check("badfcs_ndone", 48'(n_done - d0), 48'd1);
      check("badfcs_crc_ok", 48'(crc_seen), 48'd0);

      // Wrong destination port
      build(48'hFFFF_FFFF_FFFF, 16'h0800, 16'd6103, 1'b0);
      snap();
      send(-1, -1);
      idle(8);
      check("port_nvalid", 48'(n_valid - v0), 48'd0);
      check("port_ndrop", 48'(n_drop - p0), 48'd1);
      check("port_ndone", 48'(n_done - d0), 48'd0);

      // Foreign unicast MAC
      build(48'h0200_0000_0001, 16'h0800, 16'd6102, 1'b0);
      snap();
      send(-1, -1);
      idle(8);
      check("mac_nvalid", 48'(n_valid - v0), 48'd0);
      check("mac_ndrop", 48'(n_drop - p0), 48'd1);
      check("mac_ndone", 48'(n_done - d0), 48'd0);

      // ARP ethertype
      build(48'hFFFF_FFFF_FFFF, 16'h0806, 16'd6102, 1'b0);
      snap();
      send(-1, -1);
      idle(8);
      check("arp_nvalid", 48'(n_valid - v0), 48'd0);
      check("arp_ndrop", 48'(n_drop - p0), 48'd1);
      check("arp_ndone", 48'(n_done - d0), 48'd0);

      // Station MAC with rx_er on payload byte 5
      build(48'h000a_3501_feca, 16'h0800, 16'd6102, 1'b0);
      snap();
      send(47, -1);
      idle(8);
      check("er_nvalid", 48'(n_valid - v0), 48'd22);
      check("er_ndone", 48'(n_done - d0), 48'd1);
      check("er_crc_ok", 48'(crc_seen), 48'd0);

      // Reset at payload byte 10, then a good frame
      build(48'hFFFF_FFFF_FFFF, 16'h0800, 16'd6102, 1'b0);
      snap();
      send(-1, 52);
      idle(8);
      check("rst_ndone", 48'(n_done - d0), 48'd0);
      check("rst_ndrop", 48'(n_drop - p0), 48'd0);
      check("rst_src_ip_cleared", 48'(rx_src_ip), 48'h0);
      snap();
      send(-1, -1);
      idle(8);
      check("after_rst_nvalid", 48'(n_valid - v0), 48'd22);
      check("after_rst_ndone", 48'(n_done - d0), 48'd1);
      check("after_rst_crc_ok", 48'(crc_seen), 48'd1);
      check("after_rst_src_ip", 48'(rx_src_ip), 48'hC0A8_0002);

      // Back-to-back frames with a single idle cycle between them
      snap();
      send(-1, -1);
      send(-1, -1);
      idle(8);
      check("b2b_ndone", 48'(n_done - d0), 48'd2);
      check("b2b_nvalid", 48'(n_valid - v0), 48'd44);
      check("b2b_ndrop", 48'(n_drop - p0), 48'd0);
      check("b2b_crc_ok", 48'(crc_seen), 48'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
